// File: rtl/conv4_stream_feeder_if.sv
// rtl/conv4_stream_feeder_if.sv - control, row-memory and convolver bus of the conv4 stream feeder (optional cycle_count under CONV4_FEEDER_PERF_EN)
interface conv4_stream_feeder_if #(
    parameter int DATA_WIDTH  = 16,
    parameter int KERNEL_SIZE = 4,
    parameter int ADDR_W      = 12
);
    logic                              start;
    logic                              busy;
    logic                              done;
    logic                              mem_rd_en;
    logic [ADDR_W-1:0]                 mem_rd_addr;
    logic [KERNEL_SIZE*DATA_WIDTH-1:0] mem_rd_data;
    logic [KERNEL_SIZE*DATA_WIDTH-1:0] conv_data;
    logic                              conv_kernel_load;
    logic                              conv_valid_in;
    logic                              conv_valid_out;
    logic [DATA_WIDTH-1:0]             conv_result;
    logic [DATA_WIDTH-1:0]             res_data;
    logic                              res_valid;
`ifdef CONV4_FEEDER_PERF_EN
    logic [31:0]                       cycle_count;

    modport master (
        input  start, mem_rd_data, conv_result,
        output busy, done, mem_rd_en, mem_rd_addr, conv_data, conv_kernel_load,
               conv_valid_in, conv_valid_out, res_data, res_valid, cycle_count
    );
    modport slave (
        output start, mem_rd_data, conv_result,
        input  busy, done, mem_rd_en, mem_rd_addr, conv_data, conv_kernel_load,
               conv_valid_in, conv_valid_out, res_data, res_valid, cycle_count
    );
`else
    modport master (
        input  start, mem_rd_data, conv_result,
        output busy, done, mem_rd_en, mem_rd_addr, conv_data, conv_kernel_load,
               conv_valid_in, conv_valid_out, res_data, res_valid
    );
    modport slave (
        output start, mem_rd_data, conv_result,
        input  busy, done, mem_rd_en, mem_rd_addr, conv_data, conv_kernel_load,
               conv_valid_in, conv_valid_out, res_data, res_valid
    );
`endif
endinterface

// File: rtl/conv4_stream_feeder.sv
// rtl/conv4_stream_feeder.sv - streams kernel and image rows from row memory into a 4x4 convolver (optional cycle_count under CONV4_FEEDER_PERF_EN)
module conv4_stream_feeder #(
    parameter int DATA_WIDTH  = 16,
    parameter int KERNEL_SIZE = 4,
    parameter int IMG_H       = 28,
    parameter int N_STRIP     = 25,
    parameter int ADDR_W      = 12
) (
    input  logic                   clk,
    input  logic                   rst,
    conv4_stream_feeder_if.master  bus
);
    localparam int ROW_W = $clog2(IMG_H);
    localparam logic [ADDR_W-1:0] LAST_K_ADDR = ADDR_W'(3);
    localparam logic [ADDR_W-1:0] LAST_ADDR   = ADDR_W'(3 + N_STRIP * IMG_H);
    localparam logic [ROW_W-1:0]  LAST_ROW    = ROW_W'(IMG_H - 1);
    localparam logic [ROW_W-1:0]  FIRST_TAG   = ROW_W'(3);

    typedef enum logic [2:0] {
        S_IDLE, S_LOAD_K, S_STREAM, S_FLUSH, S_DRAIN, S_DONE
    } state_t;

    state_t state, state_nx;

    logic [ADDR_W-1:0] addr;
    logic [ROW_W-1:0]  row_idx;
    logic [1:0]        flush_cnt;

    logic rd_en, rd_kern, rd_tag, flush_req;
    logic rd_v1, rd_kern1, rd_tag1;
    logic push_tag, tag_d1;

    logic [KERNEL_SIZE*DATA_WIDTH-1:0] conv_data_q;
    logic                              conv_valid_in_q;
    logic                              conv_kernel_load_q;
    logic                              conv_valid_out_q;
    logic [DATA_WIDTH-1:0]             res_data_q;
    logic                              res_valid_q;

    // State register
    always_ff @(posedge clk or posedge rst) begin
        if (rst) state <= S_IDLE;
        else     state <= state_nx;
    end

    // Next state plus per-cycle read/flush strobes
    always_comb begin
        state_nx  = state;
        rd_en     = 1'b0;
        rd_kern   = 1'b0;
        rd_tag    = 1'b0;
        flush_req = 1'b0;
        case (state)
            S_IDLE: begin
                if (bus.start) state_nx = S_LOAD_K;
            end
            S_LOAD_K: begin
                rd_en   = 1'b1;
                rd_kern = 1'b1;
                if (addr == LAST_K_ADDR) state_nx = S_STREAM;
            end
            S_STREAM: begin
                rd_en  = 1'b1;
                rd_tag = (row_idx >= FIRST_TAG);
                if (addr == LAST_ADDR) state_nx = S_FLUSH;
            end
            S_FLUSH: begin
                flush_req = (flush_cnt == 2'd1);
                if (flush_cnt == 2'd2) state_nx = S_DRAIN;
            end
            S_DRAIN: begin
                // the last image row is always tagged, so the final result is the
                // res_valid with nothing left in the tag pipeline behind it
                if (res_valid_q && !conv_valid_out_q && !tag_d1 && !push_tag)
                    state_nx = S_DONE;
            end
            S_DONE: begin
                state_nx = S_IDLE;
            end
            default: state_nx = S_IDLE;
        endcase
    end

    // Read address, in-strip row index and flush timer
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            addr      <= '0;
            row_idx   <= '0;
            flush_cnt <= '0;
        end else begin
            addr      <= rd_en ? addr + ADDR_W'(1) : '0;
            if (state == S_STREAM)
                row_idx <= (row_idx == LAST_ROW) ? '0 : row_idx + ROW_W'(1);
            else
                row_idx <= '0;
            flush_cnt <= (state == S_FLUSH) ? flush_cnt + 2'd1 : 2'd0;
        end
    end

    // Read-to-push pipeline and tag-to-result pipeline
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            rd_v1              <= 1'b0;
            rd_kern1           <= 1'b0;
            rd_tag1            <= 1'b0;
            conv_data_q        <= '0;
            conv_valid_in_q    <= 1'b0;
            conv_kernel_load_q <= 1'b0;
            push_tag           <= 1'b0;
            tag_d1             <= 1'b0;
            conv_valid_out_q   <= 1'b0;
            res_data_q         <= '0;
            res_valid_q        <= 1'b0;
        end else begin
            rd_v1              <= rd_en;
            rd_kern1           <= rd_kern;
            rd_tag1            <= rd_tag;
            conv_data_q        <= rd_v1 ? bus.mem_rd_data : '0;
            conv_valid_in_q    <= rd_v1 | flush_req;
            conv_kernel_load_q <= rd_kern1;
            push_tag           <= rd_tag1;
            tag_d1             <= push_tag;
            conv_valid_out_q   <= tag_d1;
            res_valid_q        <= conv_valid_out_q;
            if (conv_valid_out_q) res_data_q <= bus.conv_result;
        end
    end

`ifdef CONV4_FEEDER_PERF_EN
    logic [31:0] cycle_count_q;

    // Busy-cycle counter for the most recent job
    always_ff @(posedge clk or posedge rst) begin
        if (rst)                              cycle_count_q <= '0;
        else if (state == S_IDLE && bus.start) cycle_count_q <= '0;
        else if (state != S_IDLE)             cycle_count_q <= cycle_count_q + 32'd1;
    end

    assign bus.cycle_count = cycle_count_q;
`endif

    assign bus.busy             = (state != S_IDLE);
    assign bus.done             = (state == S_DONE);
    assign bus.mem_rd_en        = rd_en;
    assign bus.mem_rd_addr      = rd_en ? addr : '0;
    assign bus.conv_data        = conv_data_q;
    assign bus.conv_valid_in    = conv_valid_in_q;
    assign bus.conv_kernel_load = conv_kernel_load_q;
    assign bus.conv_valid_out   = conv_valid_out_q;
    assign bus.res_data         = res_data_q;
    assign bus.res_valid        = res_valid_q;
endmodule

// File: tb/tb_conv4_stream_feeder.sv
// tb/tb_conv4_stream_feeder.sv - bench for conv4_stream_feeder (cycle_count checked when CONV4_FEEDER_PERF_EN is defined)
module tb_conv4_stream_feeder;
    localparam int HB = 5;
    localparam int NB = 2;

    logic clk = 1'b0;
    logic rst_a, rst_b;
    always #5 clk = ~clk;

    conv4_stream_feeder_if #(.DATA_WIDTH(16), .KERNEL_SIZE(4), .ADDR_W(12)) bus_a ();
    conv4_stream_feeder_if #(.DATA_WIDTH(16), .KERNEL_SIZE(4), .ADDR_W(12)) bus_b ();

    conv4_stream_feeder #(.DATA_WIDTH(16), .KERNEL_SIZE(4), .IMG_H(4), .N_STRIP(1), .ADDR_W(12))
        dut_a (.clk(clk), .rst(rst_a), .bus(bus_a.master));
    conv4_stream_feeder #(.DATA_WIDTH(16), .KERNEL_SIZE(4), .IMG_H(HB), .N_STRIP(NB), .ADDR_W(12))
        dut_b (.clk(clk), .rst(rst_b), .bus(bus_b.master));

    int errors = 0;
    int checks = 0;

    logic [63:0] mem_b [0:15];
    logic [15:0] cres_b [0:31];

    function automatic logic [63:0] row_a(input int a);
        logic [63:0] r;
        for (int l = 0; l < 4; l++) r[l*16 +: 16] = 16'(a * 16 + l + 1);
        return r;
    endfunction

    // Row memories: data one cycle after the read strobe
    always @(posedge clk) begin
        if (bus_a.mem_rd_en) bus_a.mem_rd_data <= row_a(int'(bus_a.mem_rd_addr));
        if (bus_b.mem_rd_en) bus_b.mem_rd_data <= mem_b[bus_b.mem_rd_addr[3:0]];
    end

    logic [6:0]  flags_a, flags_b;
    logic [98:0] outs_a, outs_b;
    assign flags_a = {bus_a.busy, bus_a.mem_rd_en, bus_a.conv_valid_in, bus_a.conv_kernel_load,
                      bus_a.conv_valid_out, bus_a.res_valid, bus_a.done};
    assign flags_b = {bus_b.busy, bus_b.mem_rd_en, bus_b.conv_valid_in, bus_b.conv_kernel_load,
                      bus_b.conv_valid_out, bus_b.res_valid, bus_b.done};
    assign outs_a = {bus_a.busy, bus_a.done, bus_a.mem_rd_en, bus_a.mem_rd_addr, bus_a.conv_data,
                     bus_a.conv_kernel_load, bus_a.conv_valid_in, bus_a.conv_valid_out,
                     bus_a.res_data, bus_a.res_valid};
    assign outs_b = {bus_b.busy, bus_b.done, bus_b.mem_rd_en, bus_b.mem_rd_addr, bus_b.conv_data,
                     bus_b.conv_kernel_load, bus_b.conv_valid_in, bus_b.conv_valid_out,
                     bus_b.res_data, bus_b.res_valid};

    task automatic check(input string nm, input logic [127:0] act, input logic [127:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", nm, act, exp);
        end
    endtask

    typedef struct {
        logic [15:0] cres;
        logic [6:0]  flags;
        logic [11:0] addr;
        logic [63:0] data;
        logic [15:0] res;
    } vec_t;
    vec_t tbl [0:16];

    // Single-strip 4-row job: fixed cycle-by-cycle trace from start at cycle 0
    task automatic test_a_table();
        for (int c = 0; c <= 16; c++) begin
            tbl[c].cres  = (c == 12) ? 16'h3C00 : 16'($urandom);
            tbl[c].flags = {(c >= 1 && c <= 14), (c >= 1 && c <= 8), (c >= 3 && c <= 11),
                            (c >= 3 && c <= 6), (c == 12), (c == 13), (c == 14)};
            tbl[c].addr  = 12'(c - 1);
            tbl[c].data  = (c >= 3 && c <= 10) ? row_a(c - 3) : 64'd0;
            tbl[c].res   = 16'h3C00;
        end
        for (int c = 0; c <= 16; c++) begin
            bus_a.start       = (c == 0);
            bus_a.conv_result = tbl[c].cres;
            @(negedge clk);
            check($sformatf("a_flags c=%0d", c), flags_a, tbl[c].flags);
            if (tbl[c].flags[5]) check($sformatf("a_addr c=%0d", c), bus_a.mem_rd_addr, tbl[c].addr);
            if (tbl[c].flags[4]) check($sformatf("a_data c=%0d", c), bus_a.conv_data, tbl[c].data);
            if (tbl[c].flags[1]) check($sformatf("a_res c=%0d", c), bus_a.res_data, tbl[c].res);
            @(posedge clk); #1;
        end
`ifdef CONV4_FEEDER_PERF_EN
        check("a_cycle_count", bus_a.cycle_count, 32'd14);
`endif
    endtask

    // Two-strip job against the reference model; mode 0: all 1.0 rows, 1: random,
    // 2: random with a stray start while busy; abort_at >= 0 resets the DUT in that cycle
    task automatic run_job_b(input int mode, input int abort_at);
        int nh, extra, last_res, nres;
        bit exp_rv [0:31];
        logic [6:0] ef;
        nh = NB * HB;
        for (int a = 0; a < 16; a++)
            mem_b[a] = (mode == 0) ? {4{16'h3C00}} : {$urandom, $urandom};
        extra = (mode == 2) ? int'($urandom_range(2, 18)) : -1;
        for (int i = 0; i < 32; i++) exp_rv[i] = 1'b0;
        last_res = 0;
        for (int s = 0; s < NB; s++)
            for (int r = 3; r < HB; r++) begin
                // row s,r read at address 4+s*HB+r, pushed 3 cycles after start-relative read slot
                last_res = 4 + s * HB + r + 6;
                exp_rv[last_res] = 1'b1;
            end
        nres = 0;
        for (int c = 0; c <= 22; c++) begin
            bus_b.start       = (c == 0) || (c == extra);
            cres_b[c]         = 16'($urandom);
            bus_b.conv_result = cres_b[c];
            if (c == abort_at) begin
                rst_b = 1'b1;
                @(negedge clk);
                check($sformatf("b_abort_zero c=%0d", c), outs_b, 99'd0);
                @(posedge clk); #1;
                rst_b       = 1'b0;
                bus_b.start = 1'b0;
                for (int k = 0; k < 5; k++) begin
                    @(negedge clk);
                    check($sformatf("b_after_abort k=%0d", k), outs_b, 99'd0);
                    @(posedge clk); #1;
                end
                return;
            end
            @(negedge clk);
            ef = {(c >= 1 && c <= last_res + 1), (c >= 1 && c <= nh + 4),
                  (c >= 3 && c <= nh + 7), (c >= 3 && c <= 6),
                  (c >= 1 && exp_rv[c + 1]), (c >= 1 && exp_rv[c]), (c == last_res + 1)};
            check($sformatf("b_flags m=%0d c=%0d", mode, c), flags_b, ef);
            if (ef[5]) check($sformatf("b_addr c=%0d", c), bus_b.mem_rd_addr, 12'(c - 1));
            if (ef[4]) check($sformatf("b_data c=%0d", c), bus_b.conv_data,
                             (c <= nh + 6) ? mem_b[c - 3] : 64'd0);
            if (bus_b.res_valid) begin
                nres++;
                if (ef[1]) check($sformatf("b_res c=%0d", c), bus_b.res_data, cres_b[c - 1]);
            end
            @(posedge clk); #1;
        end
        check($sformatf("b_res_count m=%0d", mode), nres, NB * (HB - 3));
    endtask

    initial begin
        rst_a = 1'b1;
        rst_b = 1'b1;
        bus_a.start = 1'b0;
        bus_b.start = 1'b0;
        bus_a.conv_result = '0;
        bus_b.conv_result = '0;
        @(posedge clk); #1;
        @(negedge clk);
        check("a_reset_zero", outs_a, 99'd0);
        check("b_reset_zero", outs_b, 99'd0);
        @(posedge clk); #1;
        rst_a = 1'b0;
        rst_b = 1'b0;
        @(posedge clk); #1;
        test_a_table();
        run_job_b(0, -1);
        run_job_b(2, -1);
        run_job_b(1, int'($urandom_range(5, 14)));
        run_job_b(1, -1);
        for (int j = 0; j < 3; j++) run_job_b(2, -1);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
